// File: rtl/cpu_defs_pkg.sv
// Shared CPU datapath types: HI/LO write source tags and the commit-slot record.
package cpu_defs_pkg;

    localparam int CPU_DATA_W = 32;

    typedef enum logic [1:0] {
        HILO_SRC_NONE = 2'd0,
        HILO_SRC_MEM  = 2'd1,
        HILO_SRC_DIV  = 2'd2
    } hilo_src_e;

    typedef struct packed {
        hilo_src_e               src;
        logic                    we_hi;
        logic                    we_lo;
        logic [CPU_DATA_W-1:0]   hi;
        logic [CPU_DATA_W-1:0]   lo;
    } hilo_wr_t;

endpackage

// File: rtl/hilo_writer_commit_slot.sv
// One-entry WB commit slot for HI/LO writes: arbitrates MEM against the divider
// handshake and holds the winning write for exactly one cycle.
module hilo_commit_slot
    import cpu_defs_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              mem_we_hi_i,
    input  logic              mem_we_lo_i,
    input  logic [DATA_W-1:0] mem_hi_i,
    input  logic [DATA_W-1:0] mem_lo_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              div_valid_i,
    input  logic [DATA_W-1:0] div_hi_i,
    input  logic [DATA_W-1:0] div_lo_i,
    output logic              div_ready_o,
    output logic              mem_wr_o,
    output logic              slot_we_hi_o,
    output logic              slot_we_lo_o,
    output logic [DATA_W-1:0] slot_hi_o,
    output logic [DATA_W-1:0] slot_lo_o
);

    hilo_src_e         src_q, src_d;
    logic              we_hi_q, we_hi_d;
    logic              we_lo_q, we_lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              mem_wr;

    assign mem_wr      = (mem_we_hi_i | mem_we_lo_i) & ~stall_i & ~flush_i;
    // Ready never looks at div_valid_i, so the divider cannot form a comb loop through it.
    assign div_ready_o = ~flush_i & ~mem_wr;

    always_comb begin
        src_d   = HILO_SRC_NONE;
        we_hi_d = 1'b0;
        we_lo_d = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (mem_wr) begin
            src_d   = HILO_SRC_MEM;
            we_hi_d = mem_we_hi_i;
            we_lo_d = mem_we_lo_i;
            hi_d    = mem_hi_i;
            lo_d    = mem_lo_i;
        end else if (div_valid_i & ~flush_i) begin
            src_d   = HILO_SRC_DIV;
            we_hi_d = 1'b1;
            we_lo_d = 1'b1;
            hi_d    = div_hi_i;
            lo_d    = div_lo_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            src_q   <= HILO_SRC_NONE;
            we_hi_q <= 1'b0;
            we_lo_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            src_q   <= src_d;
            we_hi_q <= we_hi_d;
            we_lo_q <= we_lo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign mem_wr_o     = mem_wr;
    assign slot_we_hi_o = (src_q != HILO_SRC_NONE) & we_hi_q;
    assign slot_we_lo_o = (src_q != HILO_SRC_NONE) & we_lo_q;
    assign slot_hi_o    = hi_q;
    assign slot_lo_o    = lo_q;

endmodule

// File: rtl/hilo_writer.sv
// Architectural HI/LO register pair with a one-cycle commit slot and a fully
// forwarded HI/LO view for the EX-stage operand select.
module hilo_writer
    import cpu_defs_pkg::*;
#(
    parameter int                 DATA_W    = CPU_DATA_W,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              mem_we_hi_i,
    input  logic              mem_we_lo_i,
    input  logic [DATA_W-1:0] mem_hi_i,
    input  logic [DATA_W-1:0] mem_lo_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              div_valid_i,
    input  logic [DATA_W-1:0] div_hi_i,
    input  logic [DATA_W-1:0] div_lo_i,
    output logic              div_ready_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [DATA_W-1:0] hi_arch_o,
    output logic [DATA_W-1:0] lo_arch_o
);

    logic              mem_wr;
    logic              slot_we_hi;
    logic              slot_we_lo;
    logic [DATA_W-1:0] slot_hi;
    logic [DATA_W-1:0] slot_lo;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    hilo_commit_slot #(
        .DATA_W (DATA_W)
    ) u_slot (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .mem_we_hi_i  (mem_we_hi_i),
        .mem_we_lo_i  (mem_we_lo_i),
        .mem_hi_i     (mem_hi_i),
        .mem_lo_i     (mem_lo_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .div_valid_i  (div_valid_i),
        .div_hi_i     (div_hi_i),
        .div_lo_i     (div_lo_i),
        .div_ready_o  (div_ready_o),
        .mem_wr_o     (mem_wr),
        .slot_we_hi_o (slot_we_hi),
        .slot_we_lo_o (slot_we_lo),
        .slot_hi_o    (slot_hi),
        .slot_lo_o    (slot_lo)
    );

    // Slot commit is unconditional: stall/flush only gate what enters the slot.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (slot_we_hi) hi_d = slot_hi;
        if (slot_we_lo) lo_d = slot_lo;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hi_q <= RESET_VAL;
            lo_q <= RESET_VAL;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Youngest write wins per half; divider data is only visible once it sits in the slot.
    assign hi_o = (mem_wr & mem_we_hi_i) ? mem_hi_i :
                  slot_we_hi             ? slot_hi  : hi_q;
    assign lo_o = (mem_wr & mem_we_lo_i) ? mem_lo_i :
                  slot_we_lo             ? slot_lo  : lo_q;

    assign hi_arch_o = hi_q;
    assign lo_arch_o = lo_q;

endmodule

// File: tb/tb_hilo_writer.sv
// Randomized + directed bench for hilo_writer against a pending-write queue model.
module tb_hilo_writer;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        mem_we_hi_i, mem_we_lo_i;
    logic [31:0] mem_hi_i, mem_lo_i;
    logic        stall_i, flush_i;
    logic        div_valid_i;
    logic [31:0] div_hi_i, div_lo_i;
    logic        div_ready_o;
    logic [31:0] hi_o, lo_o, hi_arch_o, lo_arch_o;

    hilo_writer #(.DATA_W(32), .RESET_VAL(32'h0)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .mem_we_hi_i (mem_we_hi_i),
        .mem_we_lo_i (mem_we_lo_i),
        .mem_hi_i    (mem_hi_i),
        .mem_lo_i    (mem_lo_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .div_valid_i (div_valid_i),
        .div_hi_i    (div_hi_i),
        .div_lo_i    (div_lo_i),
        .div_ready_o (div_ready_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .hi_arch_o   (hi_arch_o),
        .lo_arch_o   (lo_arch_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          we_hi;
        bit          we_lo;
        logic [31:0] hi;
        logic [31:0] lo;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] arch_hi, arch_lo;
    wr_t         pend_q[$];
    bit          div_pend;
    logic [31:0] div_hi_m, div_lo_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        mem_we_hi_i = 1'b0; mem_we_lo_i = 1'b0;
        mem_hi_i = 32'h0;   mem_lo_i = 32'h0;
        stall_i = 1'b0;     flush_i = 1'b0;
    endtask

    task automatic model_reset();
        arch_hi = 32'h0; arch_lo = 32'h0;
        pend_q.delete();
        div_pend = 1'b0;
    endtask

    // One clock: inputs already set after the previous edge; check at negedge, then advance.
    task automatic step();
        bit          mem_wr, exp_rdy;
        logic [31:0] fh, fl;
        div_valid_i = div_pend;
        div_hi_i    = div_hi_m;
        div_lo_i    = div_lo_m;
        @(negedge clk_i);
        mem_wr  = (mem_we_hi_i | mem_we_lo_i) & ~stall_i & ~flush_i;
        exp_rdy = !flush_i && !mem_wr;
        fh = arch_hi; fl = arch_lo;
        foreach (pend_q[i]) begin
            if (pend_q[i].we_hi) fh = pend_q[i].hi;
            if (pend_q[i].we_lo) fl = pend_q[i].lo;
        end
        if (mem_wr && mem_we_hi_i) fh = mem_hi_i;
        if (mem_wr && mem_we_lo_i) fl = mem_lo_i;
        chk("div_ready", {31'h0, div_ready_o}, {31'h0, exp_rdy});
        chk("hi_fwd", hi_o, fh);
        chk("lo_fwd", lo_o, fl);
        chk("hi_arch", hi_arch_o, arch_hi);
        chk("lo_arch", lo_arch_o, arch_lo);
        @(posedge clk_i);
        if (pend_q.size() > 0) begin
            wr_t w = pend_q.pop_front();
            if (w.we_hi) arch_hi = w.hi;
            if (w.we_lo) arch_lo = w.lo;
        end
        if (mem_wr)
            pend_q.push_back('{mem_we_hi_i, mem_we_lo_i, mem_hi_i, mem_lo_i});
        else if (div_pend && !flush_i) begin
            pend_q.push_back('{1'b1, 1'b1, div_hi_m, div_lo_m});
            div_pend = 1'b0;
        end
        #1;
    endtask

    initial begin
        rst_n_i = 1'b0;
        set_idle();
        model_reset();
        div_hi_m = 32'h0; div_lo_m = 32'h0;
        div_valid_i = 1'b0; div_hi_i = 32'h0; div_lo_i = 32'h0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Reset state
        step();
        chk("rst_hi_arch", hi_arch_o, 32'h0);

        // mthi forwarded at once, committed after two edges, LO untouched
        mem_we_hi_i = 1'b1; mem_hi_i = 32'h1234_5678; mem_lo_i = 32'hDEAD_BEEF;
        step();
        set_idle();
        step();
        chk("t2_hi_arch", hi_arch_o, 32'h1234_5678);
        chk("t2_lo_arch", lo_arch_o, 32'h0);

        // DIV collides with mtlo: MEM first, DIV next cycle
        div_pend = 1'b1; div_hi_m = 32'h0000_0077; div_lo_m = 32'h0000_0088;
        mem_we_lo_i = 1'b1; mem_lo_i = 32'h0000_0055;
        step();
        set_idle();
        step();
        chk("t3_lo_mem", lo_arch_o, 32'h0000_0055);
        step();
        chk("t3_hi_div", hi_arch_o, 32'h0000_0077);
        chk("t3_lo_div", lo_arch_o, 32'h0000_0088);

        // Stalled and flushed mthi never lands
        mem_we_hi_i = 1'b1; mem_hi_i = 32'hBAD0_0001; stall_i = 1'b1;
        step();
        stall_i = 1'b0; flush_i = 1'b1; mem_hi_i = 32'hBAD0_0002;
        step();
        set_idle();
        step(); step();
        chk("t4_hi_kept", hi_arch_o, 32'h0000_0077);

        // mthi then mtlo back-to-back
        mem_we_hi_i = 1'b1; mem_hi_i = 32'hA;
        step();
        mem_we_hi_i = 1'b0; mem_we_lo_i = 1'b1; mem_lo_i = 32'hB;
        step();
        set_idle();
        step();
        chk("t5_hi", hi_arch_o, 32'hA);
        chk("t5_lo", lo_arch_o, 32'hB);

        // Loaded slot commits through a flush; the flushed write is dropped
        mem_we_hi_i = 1'b1; mem_hi_i = 32'hC0C0_C0C0;
        step();
        flush_i = 1'b1; mem_hi_i = 32'hD0D0_D0D0;
        step();
        set_idle();
        step();
        chk("t6_hi", hi_arch_o, 32'hC0C0_C0C0);

        // Asynchronous reset with the slot full
        mem_we_hi_i = 1'b1; mem_we_lo_i = 1'b1; mem_hi_i = 32'h1111_2222; mem_lo_i = 32'h3333_4444;
        step();
        set_idle();
        div_valid_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_hi", hi_o, 32'h0);
        chk("rst_mid_lo", lo_o, 32'h0);
        chk("rst_mid_hi_arch", hi_arch_o, 32'h0);
        chk("rst_mid_lo_arch", lo_arch_o, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (!div_pend && ($urandom_range(0, 3) == 0)) begin
                div_pend = 1'b1;
                div_hi_m = $urandom;
                div_lo_m = $urandom;
            end
            mem_we_hi_i = ($urandom_range(0, 2) == 0);
            mem_we_lo_i = ($urandom_range(0, 2) == 0);
            mem_hi_i    = $urandom;
            mem_lo_i    = $urandom;
            stall_i     = ($urandom_range(0, 5) == 0);
            flush_i     = ($urandom_range(0, 7) == 0);
            step();
        end
        set_idle();
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
